mat_rowsumsq: RTL and testbench

//  Sequential row-wise sum-of-squares over an unsigned fixed-point matrix:
//    f[r][1] = sum over c of a[r][c]^2.

---
 rtl/mat_rowsumsq_if.sv | 23 ++
 rtl/mat_rowsumsq.sv | 116 +++++++++++
 tb/tb_mat_rowsumsq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mat_rowsumsq_if.sv
// Matrix-level valid/ready bundle between a matrix producer and mat_rowsumsq.
interface mat_rowsumsq_if #(
  parameter int unsigned ROWS  = 1,
  parameter int unsigned COLS  = 1,
  parameter int unsigned WIDTH = 16
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] a;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [ROWS-1:0][WIDTH-1:0]           f;

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, f
  );

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, f
  );
endinterface

// File: rtl/mat_rowsumsq.sv
// Row-wise saturating sum of squares of an unsigned fixed-point matrix,
// one column per clock, with matrix-level valid/ready on both sides.
module mat_rowsumsq #(
  parameter int unsigned ROWS  = 1,
  parameter int unsigned COLS  = 1,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SCALE = 8
) (
  input logic           clk,
  input logic           rst,
  mat_rowsumsq_if.slave bus
);
  localparam int unsigned CW = $clog2(COLS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                               state_q, state_d;
  logic [CW-1:0]                        col_q, col_d;
  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] a_q, a_d;
  logic [ROWS-1:0][WIDTH-1:0]           acc_q, acc_d, f_q, f_d;
  logic                                 in_ready_q, in_ready_d;
  logic                                 out_valid_q, out_valid_d;

  logic [ROWS-1:0][WIDTH-1:0]           sel;
  logic [ROWS-1:0][2*WIDTH-1:0]         prod;
  logic [ROWS-1:0][WIDTH-1:0]           pw;
  logic [ROWS-1:0][WIDTH:0]             sum;
  logic [ROWS-1:0][WIDTH-1:0]           acc_nxt;

  // col counts 1..COLS, so column c is selected when col_q == c+1
  always_comb begin
    sel     = '0;
    prod    = '0;
    pw      = '0;
    sum     = '0;
    acc_nxt = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (col_q == CW'(c + 1)) sel[r] = a_q[r][c];
      end
      prod[r]    = ({{WIDTH{1'b0}}, sel[r]} * {{WIDTH{1'b0}}, sel[r]}) >> SCALE;
      pw[r]      = (|prod[r][2*WIDTH-1:WIDTH]) ? '1 : prod[r][WIDTH-1:0];
      sum[r]     = {1'b0, acc_q[r]} + {1'b0, pw[r]};
      acc_nxt[r] = sum[r][WIDTH] ? '1 : sum[r][WIDTH-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    a_d         = a_q;
    acc_d       = acc_q;
    f_d         = f_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.a;
          acc_d      = '0;
          col_d      = CW'(1);
          in_ready_d = 1'b0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_nxt;
        col_d = col_q + CW'(1);
        if (col_q == CW'(COLS)) begin
          f_d         = acc_nxt;
          out_valid_d = 1'b1;
          col_d       = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        // in_ready rises only after the handoff cycle, never alongside it
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        col_d       = '0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      a_q         <= '0;
      acc_q       <= '0;
      f_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      a_q         <= a_d;
      acc_q       <= acc_d;
      f_q         <= f_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.f         = f_q;
endmodule

// File: tb/tb_mat_rowsumsq.sv
// Directed + randomized bench for mat_rowsumsq (WIDTH=16, SCALE=8) across three shapes.
module tb_mat_rowsumsq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mat_rowsumsq_if #(.ROWS(2), .COLS(2), .WIDTH(16)) ia ();
  mat_rowsumsq_if #(.ROWS(1), .COLS(3), .WIDTH(16)) ib ();
  mat_rowsumsq_if #(.ROWS(1), .COLS(4), .WIDTH(16)) ic ();

  mat_rowsumsq #(.ROWS(2), .COLS(2), .WIDTH(16), .SCALE(8)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  mat_rowsumsq #(.ROWS(1), .COLS(3), .WIDTH(16), .SCALE(8)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  mat_rowsumsq #(.ROWS(1), .COLS(4), .WIDTH(16), .SCALE(8)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: square, drop SCALE fraction bits, clamp, then clamp the running sum.
  function automatic logic [15:0] row_exp(input logic [63:0] row, input int n);
    longint unsigned acc = 0;
    longint unsigned x, p;
    for (int i = 0; i < n; i++) begin
      x = 64'(row[16*i +: 16]);
      p = (x * x) >> 8;
      if (p > 65535) p = 65535;
      acc = acc + p;
      if (acc > 65535) acc = 65535;
    end
    return acc[15:0];
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom_range(0, 1023));
      1:       return 16'($urandom_range(61440, 65535));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic run_a(input logic [1:0][1:0][15:0] m, input int hold, input string tag);
    logic [1:0][15:0] e;
    int n;
    for (int r = 0; r < 2; r++) e[r] = row_exp(64'(m[r]), 2);
    ia.a = m;
    ia.in_valid = 1'b1;
    ia.out_ready = 1'b0;
    step();
    ia.in_valid = 1'b0;
    ia.a = {$urandom, $urandom};
    n = 0;
    while (!ia.out_valid && n < 20) begin step(); n++; end
    chk({tag, "_latency"}, 64'(n), 64'd2);
    chk({tag, "_f"}, 64'(ia.f), 64'(e));
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold_valid"}, 64'(ia.out_valid), 64'd1);
      chk({tag, "_hold_inrdy"}, 64'(ia.in_ready), 64'd0);
      chk({tag, "_hold_f"}, 64'(ia.f), 64'(e));
    end
    ia.out_ready = 1'b1;
    step();
    ia.out_ready = 1'b0;
    chk({tag, "_post_inrdy"}, 64'(ia.in_ready), 64'd1);
    chk({tag, "_post_valid"}, 64'(ia.out_valid), 64'd0);
  endtask

  task automatic run_b(input logic [2:0][15:0] m, input string tag);
    int n;
    ib.a = m;
    ib.in_valid = 1'b1;
    ib.out_ready = 1'b0;
    step();
    ib.in_valid = 1'b0;
    ib.a = 48'({$urandom, $urandom});
    n = 0;
    while (!ib.out_valid && n < 20) begin step(); n++; end
    chk({tag, "_latency"}, 64'(n), 64'd3);
    chk({tag, "_f"}, 64'(ib.f), 64'(row_exp(64'(m), 3)));
    ib.out_ready = 1'b1;
    step();
    ib.out_ready = 1'b0;
    chk({tag, "_post_inrdy"}, 64'(ib.in_ready), 64'd1);
  endtask

  task automatic run_c(input logic [3:0][15:0] m, input string tag);
    int n;
    ic.a = m;
    ic.in_valid = 1'b1;
    ic.out_ready = 1'b0;
    step();
    ic.in_valid = 1'b0;
    ic.a = {$urandom, $urandom};
    n = 0;
    while (!ic.out_valid && n < 20) begin step(); n++; end
    chk({tag, "_latency"}, 64'(n), 64'd4);
    chk({tag, "_f"}, 64'(ic.f), 64'(row_exp(64'(m), 4)));
    ic.out_ready = 1'b1;
    step();
    ic.out_ready = 1'b0;
  endtask

  initial begin
    logic [1:0][1:0][15:0] ma;
    logic [2:0][15:0]      mb;
    logic [3:0][15:0]      mc;
    logic [1:0][1:0][15:0] bm[3];
    logic [1:0][15:0]      be[3];
    int                    acc_cyc[3];
    int                    nacc, nres;
    bit                    took, got;

    ia.in_valid = 1'b0; ia.out_ready = 1'b0; ia.a = '0;
    ib.in_valid = 1'b0; ib.out_ready = 1'b0; ib.a = '0;
    ic.in_valid = 1'b0; ic.out_ready = 1'b0; ic.a = '0;
    step();
    chk("reset_inrdy", 64'(ia.in_ready), 64'd1);
    chk("reset_valid", 64'(ia.out_valid), 64'd0);
    chk("reset_f", 64'(ia.f), 64'd0);
    step();
    rst = 1'b0;

    // a=[[1.0,2.0],[0.5,0.5]] -> [0x0500, 0x0080]
    ma[0][0] = 16'h0100; ma[0][1] = 16'h0200;
    ma[1][0] = 16'h0080; ma[1][1] = 16'h0080;
    run_a(ma, 0, "t1");
    chk("t1_row0_const", 64'(ia.f[0]), 64'h0500);
    chk("t1_row1_const", 64'(ia.f[1]), 64'h0080);

    // Sub-LSB truncation in row 0, exact squares in row 1; held 10 cycles.
    ma[0][0] = 16'h0001; ma[0][1] = 16'h0001;
    ma[1][0] = 16'h0100; ma[1][1] = 16'h0100;
    run_a(ma, 10, "t34");
    chk("t3_row0_const", 64'(ia.f[0]), 64'h0000);

    mb[0] = 16'hFF00; mb[1] = 16'h0100; mb[2] = 16'h0100;
    run_b(mb, "t2");
    chk("t2_sat_const", 64'(ib.f), 64'hFFFF);

    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) ma[r][c] = rnd16();
      run_a(ma, $urandom_range(0, 3), "rand_a");
      for (int c = 0; c < 3; c++) mb[c] = rnd16();
      run_b(mb, "rand_b");
    end

    // Reset during the second ACCUM cycle of a COLS=4 matrix.
    for (int c = 0; c < 4; c++) mc[c] = rnd16();
    ic.a = mc;
    ic.in_valid = 1'b1;
    step();
    ic.in_valid = 1'b0;
    step();
    chk("t5_busy", 64'(ic.in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(ic.out_valid), 64'd0);
    chk("t5_rst_inrdy", 64'(ic.in_ready), 64'd1);
    #1;
    rst = 1'b0;
    step();
    for (int c = 0; c < 4; c++) mc[c] = 16'h0100;
    run_c(mc, "t5_after");
    chk("t5_f_const", 64'(ic.f), 64'h0400);

    // Back-to-back: in_valid held, out_ready held.
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) bm[k][r][c] = rnd16();
      for (int r = 0; r < 2; r++) be[k][r] = row_exp(64'(bm[k][r]), 2);
    end
    ia.a = bm[0];
    ia.in_valid = 1'b1;
    ia.out_ready = 1'b1;
    nacc = 0;
    nres = 0;
    for (int cyc = 0; cyc < 60 && nres < 3; cyc++) begin
      took = ia.in_valid && ia.in_ready;
      got  = ia.out_valid && ia.out_ready;
      if (got) begin
        chk("t6_f", 64'(ia.f), 64'(be[nres]));
        nres++;
      end
      if (took) begin
        acc_cyc[nacc] = cyc;
        nacc++;
      end
      step();
      if (took) begin
        if (nacc < 3) ia.a = bm[nacc];
        else ia.in_valid = 1'b0;
      end
    end
    ia.out_ready = 1'b0;
    chk("t6_nres", 64'(nres), 64'd3);
    chk("t6_nacc", 64'(nacc), 64'd3);
    if (nacc == 3) begin
      chk("t6_space01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd4);
      chk("t6_space12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd4);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
